aes_spi_scheduler: RTL
======================

# aes_spi_scheduler

Controller that sequences the SPI main master on behalf of two independent requesters, e.g. key-load and data-block engines. It arbitrates round-robin, builds the 258-bit transmit frame for the granted request, and pulses the master's start. It then waits for done, captures the 128-bit received block and returns it to the owning requester with an ID and error flag. It sits between the AES-side logic and the SPI main instance; only one SPI transaction is ever in flight.

## Interface
- TIMEOUT_CYCLES, 4096: clk cycles allowed in WAIT before the transaction is abandoned with error.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester accept; transfer when valid & ready on a clk edge.
- req_op0, req_op1  in  2 each  opcode: 00 = 128-bit payload, 01 = 192-bit, 10 = 256-bit, 11 = illegal.
- req_data0, req_data1  in  256 each  payload, bit 0 first on the wire; unused tail bits ignored.
- rsp_valid  out  1  one-cycle pulse, response available.
- rsp_id  out  1  requester that owns the response.
- rsp_data  out  128  received block, rx bit 0 = first bit received.
- rsp_err  out  1  1 = illegal opcode or timeout; rsp_data = 0 then.
- spi_tx  out  258  frame to SPI main.
- spi_start  out  1  start pulse to SPI main.
- spi_done  in  1  SPI main done; level, cleared by the master when it accepts start.
- spi_rx  in  128  SPI main received data.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, LOAD, START, WAIT, RESP.
- IDLE: if any req_valid, grant by round-robin pointer `last`: prefer requester !last, else last. req_ready[g]=1 combinationally in IDLE only, for the granted requester only. On handshake, latch op, data and id; last <= g. Go to LOAD, or to RESP with err=1 if op == 11; no SPI activity then.
- LOAD: build frame. size = 130/194/258 for op 00/01/10. spi_tx[0:1] = op. Window starts at index s = 258 - size: spi_tx[s:s+1] = op, spi_tx[s+2 : 257] = data[0 : size-3]. All other bits are 0, and for op 10 both op placements coincide. spi_tx holds stable from LOAD until the next LOAD.
- START: spi_start = 1 for exactly this one cycle. Clear timeout counter.
- WAIT: ignore spi_done in the first WAIT cycle, because the stale done from the previous transaction is still high. From the second cycle on, spi_done == 1 -> capture spi_rx into rsp_data, err=0, go to RESP. If the counter reaches TIMEOUT_CYCLES -> rsp_data=0, err=1, go to RESP. The counter is 16 bits and saturates.
- RESP: rsp_valid = 1 for one cycle with id, data and err; return to IDLE. No response backpressure: the consumer must take it that cycle.
- Requests arriving while busy wait, with req_ready=0; the valid must be held until accepted.
- rst at any time: all outputs to reset values, state IDLE, last = 1 so requester 0 wins first. An in-flight SPI transaction is abandoned; its done is ignored by the first-cycle rule on the next transaction.

## Timing
- Reset values: req_ready=00 (combinational, but state IDLE with req_valid=0 gives 00), rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, spi_tx=0, spi_start=0, busy=0.
- Accept at edge A: LOAD in A+1, spi_start high in A+2, WAIT from A+3.
- Done seen high at edge D (D ≥ A+4): rsp_valid high in cycle D+1.
- Illegal op: rsp_valid in the cycle after acceptance.
- Back-to-back: next grant is possible in the cycle after RESP, so minimum request spacing is 5 cycles plus the SPI duration.

## Test plan
- Reset mid-WAIT -> all outputs zero next cycle; the next request gets spi_start 2 cycles after accept, and the stale spi_done=1 in the first WAIT cycle is ignored.
- Requester 0 op=00, data[0:127]=0x0123…CDEF; model returns rx=0xA5 repeated -> spi_tx[128:129]=00, spi_tx[130:257]=payload; rsp_valid once, rsp_id=0, rsp_data=0xA5…A5, err=0.
- Both requesters valid continuously, op=10 -> grants alternate 0,1,0,1; req_ready never has both bits high.
- req_op1=11 -> accepted; rsp_valid next cycle with id=1, err=1, data=0; spi_start never asserted.
- TIMEOUT_CYCLES=16 with spi_done held 0 -> rsp_err=1 exactly 16 WAIT cycles after START, busy then drops.
- op=01 -> spi_tx[64:65]=01, spi_tx[66:257]=data[0:191], spi_tx[2:63]=0.

Source files
------------

// File: rtl/aes_spi_scheduler.sv
// aes_spi_scheduler: round-robin arbiter and sequencer that frames AES requests onto a single SPI main master
// and returns the received 128-bit block to the owning requester.
module aes_spi_scheduler #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [1:0]   req_op0,
    input  logic [1:0]   req_op1,
    input  logic [255:0] req_data0,
    input  logic [255:0] req_data1,
    output logic         rsp_valid,
    output logic         rsp_id,
    output logic [127:0] rsp_data,
    output logic         rsp_err,
    output logic [257:0] spi_tx,
    output logic         spi_start,
    input  logic         spi_done,
    input  logic [127:0] spi_rx,
    output logic         busy
);
    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, RESP} state_t;
    state_t r_state, w_next;
    logic         r_last, r_first;
    logic [1:0]   r_op;
    logic [255:0] r_data;
    logic [15:0]  r_cnt;
    logic         w_g, w_acc, w_ill, w_done, w_to;
    logic [1:0]   w_op;
    logic [8:0]   w_s;
    logic [255:0] w_mask;
    logic [257:0] w_frame;
    assign w_g       = req_valid[~r_last] ? ~r_last : r_last;
    assign w_acc     = (r_state == IDLE) && |req_valid;
    assign w_op      = w_g ? req_op1 : req_op0;
    assign w_ill     = w_op == 2'b11;
    assign req_ready = w_acc ? (w_g ? 2'b10 : 2'b01) : 2'b00;
    // the first WAIT cycle still sees the previous transaction's done level
    assign w_done    = (r_state == WAIT) && !r_first && spi_done;
    assign w_to      = (r_state == WAIT) && (32'(r_cnt) + 32'd1 >= 32'(TIMEOUT_CYCLES));
    assign w_s       = r_op == 2'b00 ? 9'd128 : r_op == 2'b01 ? 9'd64 : 9'd0;
    assign w_mask    = r_op == 2'b00 ? {128'b0, {128{1'b1}}} : r_op == 2'b01 ? {64'b0, {192{1'b1}}} : '1;
    // op sits at bit 0 and again at the window start; they overlap for the full-size frame
    assign w_frame   = ({r_data & w_mask, r_op} << w_s) | {256'b0, r_op};
    assign spi_start = r_state == START;
    assign rsp_valid = r_state == RESP;
    assign busy      = r_state != IDLE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_acc ? (w_ill ? RESP : LOAD) : IDLE;
            LOAD:    w_next = START;
            START:   w_next = WAIT;
            WAIT:    w_next = (w_done || w_to) ? RESP : WAIT;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last   <= 1'b1;
            r_first  <= 1'b0;
            r_op     <= '0;
            r_data   <= '0;
            r_cnt    <= '0;
            rsp_id   <= 1'b0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            spi_tx   <= '0;
        end else begin
            if (w_acc) begin
                r_last   <= w_g;
                rsp_id   <= w_g;
                r_op     <= w_op;
                r_data   <= w_g ? req_data1 : req_data0;
                rsp_data <= '0;
                rsp_err  <= w_ill;
            end
            if (r_state == LOAD) spi_tx <= w_frame;
            if (r_state == START) begin
                r_cnt   <= '0;
                r_first <= 1'b1;
            end
            if (r_state == WAIT) begin
                r_first <= 1'b0;
                r_cnt   <= &r_cnt ? r_cnt : r_cnt + 16'd1;
                if (w_done || w_to) begin
                    rsp_data <= w_done ? spi_rx : '0;
                    rsp_err  <= !w_done;
                end
            end
        end
    end
endmodule
